motion_sequencer: RTL and testbench

//  Timed manoeuvre scheduler between the colour classifier and the H-bridge pins.

---
 rtl/motion_pkg.sv | 36 +++
 rtl/motion_timer.sv | 38 +++
 rtl/motion_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_motion_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// motion_pkg
//   Shared definitions for the motion sequencer:
//   - 2-bit motion command codes
//   - FSM state encodings, which are also shown on the debug state output
//   - 6-bit H-bridge patterns in the bit order {e1,e2,as2,as1,bs2,bs1}
//   - cmd_pattern(): maps a command code to its pin pattern
package motion_pkg;

    localparam logic [1:0] CMD_LEFT    = 2'b00;
    localparam logic [1:0] CMD_FORWARD = 2'b01;
    localparam logic [1:0] CMD_RIGHT   = 2'b10;
    localparam logic [1:0] CMD_STOP    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_COAST   = 2'b10,
        ST_BLOCKED = 2'b11
    } state_t;

    localparam logic [5:0] PAT_FORWARD = 6'b111010;
    localparam logic [5:0] PAT_LEFT    = 6'b111110;
    localparam logic [5:0] PAT_RIGHT   = 6'b111011;
    localparam logic [5:0] PAT_OFF     = 6'b000000;

    // A stop command is a timed manoeuvre that drives the all-off pattern.
    function automatic logic [5:0] cmd_pattern(input logic [1:0] code);
        case (code)
            CMD_LEFT:    return PAT_LEFT;
            CMD_FORWARD: return PAT_FORWARD;
            CMD_RIGHT:   return PAT_RIGHT;
            default:     return PAT_OFF;
        endcase
    endfunction

endpackage

// File: rtl/motion_timer.sv
// motion_timer
//   Loadable down-counter. The count saturates at zero. A load takes
//   priority over a decrement.
// Ports:
//   clock     in   system clock
//   reset     in   synchronous active-high reset, clears the count
//   load      in   load load_val this cycle
//   load_val  in   CNT_W-bit value to load
//   en        in   decrement this cycle when the count is non-zero
//   zero      out  count is zero
module motion_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: non-blocking assignments in sequential logic, so every register
    // samples the values that existed before this clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/motion_sequencer.sv
// motion_sequencer
//   Timed manoeuvre scheduler that sits between the colour classifier and the
//   H-bridge. It accepts one command per valid/ready handshake, drives the
//   matching pattern for HOLD_CYCLES, and then coasts for GAP_CYCLES. When
//   proximity is high, the sequencer aborts everything and stays BLOCKED
//   until proximity has read 0 for CLEAR_CYCLES consecutive cycles.
//   Optional feature macro: MOTION_QUEUE_EN. When this macro is defined, a
//   one-entry pending command register is added. The sequencer then accepts
//   a command during RUN/COAST and starts it straight after the gap.
// Ports:
//   clock, reset         system clock; synchronous active-high reset
//   cmd_valid, cmd_code  command handshake input (00 L, 01 F, 10 R, 11 stop)
//   cmd_ready            a command is accepted when cmd_valid && cmd_ready
//   proximity            obstacle flag, already synchronous to clock
//   e1,e2,as1,as2,bs1,bs2  H-bridge enable and direction pins
//   busy                 state is not IDLE
//   state_o              FSM state (00 IDLE, 01 RUN, 10 COAST, 11 BLOCKED)
module motion_sequencer
    import motion_pkg::*;
#(
    parameter int HOLD_CYCLES  = 20000000,
    parameter int GAP_CYCLES   = 1000000,
    parameter int CLEAR_CYCLES = 500000,
    parameter int CNT_W        = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_code,
    output logic       cmd_ready,
    input  logic       proximity,
    output logic       e1,
    output logic       e2,
    output logic       as1,
    output logic       as2,
    output logic       bs1,
    output logic       bs2,
    output logic       busy,
    output logic [1:0] state_o
);

    // The timers count N-1 down to 0, so each phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] HOLD_LOAD  =
        (HOLD_CYCLES  > 0) ? CNT_W'(HOLD_CYCLES - 1)  : '0;
    localparam logic [CNT_W-1:0] GAP_LOAD   =
        (GAP_CYCLES   > 0) ? CNT_W'(GAP_CYCLES - 1)   : '0;
    localparam logic [CNT_W-1:0] CLEAR_LOAD =
        (CLEAR_CYCLES > 0) ? CNT_W'(CLEAR_CYCLES - 1) : '0;

    state_t           state, state_next;
    logic [1:0]       cur_code, cur_code_next;
    logic             accept;
    logic             phase_done;
    logic             pending;
    logic [1:0]       pending_code;
    logic             step_load, step_en, step_zero;
    logic [CNT_W-1:0] step_load_val;
    logic             clear_zero;
    logic [5:0]       pins;

    assign accept = cmd_valid && cmd_ready;

`ifdef MOTION_QUEUE_EN
    logic       slot_full;
    logic [1:0] slot_code;

    // A command that arrives on the final gap cycle starts directly. It is
    // never parked in the slot, because the slot is only read at phase end.
    assign pending      = slot_full || (accept && state != ST_IDLE);
    assign pending_code = slot_full ? slot_code : cmd_code;

    always_comb begin
        cmd_ready = 1'b0;
        if (!proximity) begin
            cmd_ready = (state == ST_IDLE) ||
                        ((state == ST_RUN || state == ST_COAST) && !slot_full);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || proximity) begin
            slot_full <= 1'b0;
            slot_code <= CMD_LEFT;
        end else if (phase_done && pending) begin
            slot_full <= 1'b0;
        end else if (accept && state != ST_IDLE) begin
            slot_full <= 1'b1;
            slot_code <= cmd_code;
        end
    end
`else
    assign pending      = 1'b0;
    assign pending_code = cmd_code;
    assign cmd_ready    = !proximity && (state == ST_IDLE);
`endif

    // NOTE: every combinational output gets a default value first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        state_next    = state;
        cur_code_next = cur_code;
        step_load     = 1'b0;
        step_load_val = HOLD_LOAD;
        step_en       = 1'b0;
        phase_done    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next    = ST_RUN;
                    cur_code_next = cmd_code;
                    step_load     = 1'b1;
                end
            end
            ST_RUN: begin
                if (!step_zero) begin
                    step_en = 1'b1;
                end else if (GAP_CYCLES != 0) begin
                    state_next    = ST_COAST;
                    step_load     = 1'b1;
                    step_load_val = GAP_LOAD;
                end else begin
                    phase_done = 1'b1;
                end
            end
            ST_COAST: begin
                if (!step_zero) step_en = 1'b1;
                else            phase_done = 1'b1;
            end
            ST_BLOCKED: begin
                if (clear_zero) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (phase_done) begin
            if (pending) begin
                state_next    = ST_RUN;
                cur_code_next = pending_code;
                step_load     = 1'b1;
                step_load_val = HOLD_LOAD;
            end else begin
                state_next = ST_IDLE;
            end
        end

        // Proximity overrides every transition, including a phase ending.
        if (proximity) begin
            state_next = ST_BLOCKED;
            phase_done = 1'b0;
            step_load  = 1'b0;
            step_en    = 1'b0;
        end
    end

    // NOTE: this reset is synchronous, so it appears only inside the
    // clocked branch and takes effect on the edge where it is sampled high.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            cur_code <= CMD_LEFT;
        end else begin
            state    <= state_next;
            cur_code <= cur_code_next;
        end
    end

    motion_timer #(.CNT_W(CNT_W)) u_step_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (step_load),
        .load_val (step_load_val),
        .en       (step_en),
        .zero     (step_zero)
    );

    // This timer reloads on every proximity=1 cycle, which restarts the run
    // of consecutive zero readings. It counts only while the path reads clear.
    motion_timer #(.CNT_W(CNT_W)) u_clear_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (proximity),
        .load_val (CLEAR_LOAD),
        .en       (state == ST_BLOCKED),
        .zero     (clear_zero)
    );

    assign pins    = (state == ST_RUN) ? cmd_pattern(cur_code) : PAT_OFF;
    assign {e1, e2, as2, as1, bs2, bs1} = pins;
    assign busy    = (state != ST_IDLE);
    assign state_o = state;

endmodule

// File: tb/tb_motion_sequencer.sv
module tb_motion_sequencer;

    localparam int HOLD  = 8;
    localparam int GAP   = 2;
    localparam int CLEAR = 3;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_COAST   = 2;
    localparam int M_BLOCKED = 3;

`ifdef MOTION_QUEUE_EN
    localparam bit QUEUE_EN = 1'b1;
`else
    localparam bit QUEUE_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset, cmd_valid, proximity;
    logic [1:0] cmd_code;
    logic       cmd_ready, e1, e2, as1, as2, bs1, bs2, busy;
    logic [1:0] state_o;

    always #5 clock = ~clock;

    motion_sequencer #(
        .HOLD_CYCLES  (HOLD),
        .GAP_CYCLES   (GAP),
        .CLEAR_CYCLES (CLEAR),
        .CNT_W        (26)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_ready (cmd_ready),
        .proximity (proximity),
        .e1        (e1),
        .e2        (e2),
        .as1       (as1),
        .as2       (as2),
        .bs1       (bs1),
        .bs2       (bs2),
        .busy      (busy),
        .state_o   (state_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a mode plus counts of cycles still to go in the current phase.
    logic [5:0] pat_table [4] = '{6'b111110, 6'b111010, 6'b111011, 6'b000000};
    int         m_mode  = M_IDLE;
    int         m_left  = 0;
    int         m_zeros = 0;
    logic [1:0] m_code  = 2'b00;
    bit         q_full  = 1'b0;
    logic [1:0] q_code  = 2'b00;

    function automatic logic [5:0] exp_pins();
        return (m_mode == M_RUN) ? pat_table[m_code] : 6'b000000;
    endfunction

    function automatic bit exp_ready(input logic p);
        if (p) return 1'b0;
        if (m_mode == M_IDLE) return 1'b1;
        return QUEUE_EN && (m_mode == M_RUN || m_mode == M_COAST) && !q_full;
    endfunction

    task automatic model_step(input logic r, input bit hs, input logic [1:0] c, input logic p);
        if (r) begin
            m_mode = M_IDLE; m_left = 0; m_zeros = 0; q_full = 1'b0;
        end else if (p) begin
            m_mode = M_BLOCKED; m_zeros = 0; q_full = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (hs) begin m_mode = M_RUN; m_code = c; m_left = HOLD; end
                M_RUN, M_COAST: begin
                    if (hs) begin q_full = 1'b1; q_code = c; end
                    m_left--;
                    if (m_left == 0) begin
                        if (m_mode == M_RUN && GAP > 0) begin
                            m_mode = M_COAST; m_left = GAP;
                        end else if (q_full) begin
                            m_mode = M_RUN; m_code = q_code; m_left = HOLD; q_full = 1'b0;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
                default: begin
                    m_zeros++;
                    if (m_zeros == CLEAR) m_mode = M_IDLE;
                end
            endcase
        end
    endtask

    // Called at a falling edge: drive the inputs, compare the outputs, clock once, and advance the model.
    task automatic tick(input logic r, input logic v, input logic [1:0] c, input logic p, input bit cmp);
        bit hs;
        reset = r; cmd_valid = v; cmd_code = c; proximity = p;
        #1;
        if (cmp) begin
            check("pins", 32'({e1, e2, as2, as1, bs2, bs1}), 32'(exp_pins()));
            check("cmd_ready", 32'(cmd_ready), 32'(exp_ready(p)));
            check("state_o", 32'(state_o), 32'(m_mode));
            check("busy", 32'(busy), 32'(m_mode != M_IDLE));
        end
        hs = v && exp_ready(p);
        @(posedge clock);
        model_step(r, hs, c, p);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_code = 2'b00; proximity = 1'b0;
        @(negedge clock);
        tick(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_ready", 32'(cmd_ready), 32'd1);

        // Forward command: accepted at T, pattern for T+1..T+8, coast, ready again at T+11.
        tick(1'b0, 1'b1, 2'b01, 1'b0, 1'b1);
        check("fwd_pins", 32'({e1, e2, as2, as1, bs2, bs1}), 32'(6'b111010));
        idle(HOLD);
        check("fwd_coast", 32'({e1, e2, as2, as1, bs2, bs1}), 32'd0);
        idle(GAP);
        check("fwd_ready_again", 32'(cmd_ready), 32'd1);
        idle(2);

        // Left, then right held valid: the second command is held off or queued.
        tick(1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < HOLD + GAP + 1; i++) tick(1'b0, 1'b1, 2'b10, 1'b0, 1'b1);
        idle(2 * (HOLD + GAP) + 2);

        // Proximity on the 4th RUN cycle, then a 0,0,1,0,0,0 clear sequence.
        tick(1'b0, 1'b1, 2'b01, 1'b0, 1'b1);
        idle(3);
        tick(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        check("prox_state", 32'(state_o), 32'd3);
        check("prox_pins", 32'({e1, e2, as2, as1, bs2, bs1}), 32'd0);
        tick(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        check("clear_not_yet", 32'(state_o), 32'd3);
        tick(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        check("clear_idle", 32'(state_o), 32'd0);

        // Valid and proximity are high together in IDLE: proximity wins, and the command is lost.
        tick(1'b0, 1'b1, 2'b01, 1'b1, 1'b1);
        check("simul_blocked", 32'(state_o), 32'd3);
        idle(CLEAR);
        check("simul_idle", 32'(state_o), 32'd0);
        idle(2);
        check("simul_no_run", 32'(busy), 32'd0);

        // Reset in the middle of a RUN.
        tick(1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
        idle(3);
        tick(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        check("rst_pins", 32'({e1, e2, as2, as1, bs2, bs1}), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        idle(2);

`ifdef MOTION_QUEUE_EN
        // Right is queued during RUN and starts on the cycle after the last COAST cycle.
        tick(1'b0, 1'b1, 2'b01, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 2'b10, 1'b0, 1'b1);
        check("q_third_ready", 32'(cmd_ready), 32'd0);
        tick(1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
        idle(HOLD + GAP - 2);
        check("q_right_pins", 32'({e1, e2, as2, as1, bs2, bs1}), 32'(6'b111011));
        idle(HOLD + GAP + 2);
`endif

        // Randomized traffic, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            tick(1'($urandom_range(0, 299) == 0),
                 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 19) == 0),
                 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
